// File: rtl/alu_exec_pipeline_if.sv
// Operation issue / result bus for alu_exec_pipeline.
// master: the decode side that offers operations and consumes results.
// slave:  the pipeline itself.
interface alu_exec_pipeline_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NREGS = 32,
  parameter int unsigned IMMW  = 12
);
  localparam int unsigned AW = $clog2(NREGS);

  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   in_rs1;
  logic [AW-1:0]   in_rs2;
  logic [AW-1:0]   in_rd;
  logic [3:0]      in_alu_ctl;
  logic            in_use_imm;
  logic [IMMW-1:0] in_imm;
  logic            in_reg_write;

  logic            res_valid;
  logic [XLEN-1:0] res_data;
  logic [AW-1:0]   res_rd;
  logic            res_zero;
  logic            res_overflow;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_alu_ctl, in_use_imm, in_imm, in_reg_write,
    input  in_ready, res_valid, res_data, res_rd, res_zero, res_overflow
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_alu_ctl, in_use_imm, in_imm, in_reg_write,
    output in_ready, res_valid, res_data, res_rd, res_zero, res_overflow
  );
endinterface

// File: rtl/alu_exec_pipeline.sv
// Three-stage integer execute pipeline: EX register -> ALU -> WB register -> register file.
// Optional feature macro: ALU_EXEC_FWD_EN. When defined, a RAW hazard on the WB stage is
// resolved by bypassing res_data into the ALU operands; when undefined, the EX stage stalls
// for one cycle until the WB value has been committed to the register file.
module alu_exec_pipeline #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NREGS = 32,
  parameter int unsigned IMMW  = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_exec_pipeline_if.slave       bus,
  input  logic                     flush,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [XLEN-1:0]          dbg_data
);
  localparam int unsigned AW = $clog2(NREGS);
  localparam int unsigned SW = $clog2(XLEN);

  typedef enum logic [3:0] {
    AluAnd = 4'b0000,
    AluOr  = 4'b0001,
    AluAdd = 4'b0010,
    AluXor = 4'b0011,
    AluSll = 4'b0100,
    AluSrl = 4'b0101,
    AluSub = 4'b0110,
    AluSlt = 4'b0111,
    AluSra = 4'b1000
  } alu_op_e;

  typedef struct packed {
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic [3:0]      ctl;
    logic            use_imm;
    logic [IMMW-1:0] imm;
    logic            reg_write;
  } ex_op_t;

  logic            ex_valid_q, ex_valid_d;
  ex_op_t          ex_op_q, ex_op_d;
  logic            wb_valid_q, wb_valid_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [AW-1:0]   wb_rd_q, wb_rd_d;
  logic            wb_reg_write_q, wb_reg_write_d;
  logic            wb_zero_q, wb_zero_d;
  logic            wb_ovf_q, wb_ovf_d;
  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_d [NREGS];

  logic            wb_commit, haz_a, haz_b, stall, accept, advance;
  logic [XLEN-1:0] op_a, op_b, imm_ext, sum, diff, alu_res;
  logic            alu_ovf;

  // WB value that will land in the register file on the next edge; x0 never commits.
  assign wb_commit = wb_valid_q && wb_reg_write_q && (wb_rd_q != '0);
  assign haz_a     = wb_commit && (wb_rd_q == ex_op_q.rs1);
  assign haz_b     = wb_commit && (wb_rd_q == ex_op_q.rs2);
  assign imm_ext   = {{(XLEN-IMMW){ex_op_q.imm[IMMW-1]}}, ex_op_q.imm};

  // Operand selection and hazard resolution.
  always_comb begin
`ifdef ALU_EXEC_FWD_EN
    op_a  = haz_a ? wb_data_q : rf_q[ex_op_q.rs1];
    op_b  = ex_op_q.use_imm ? imm_ext : (haz_b ? wb_data_q : rf_q[ex_op_q.rs2]);
    stall = 1'b0;
`else
    op_a  = rf_q[ex_op_q.rs1];
    op_b  = ex_op_q.use_imm ? imm_ext : rf_q[ex_op_q.rs2];
    // A flushed EX op is discarded anyway, so it never needs to wait.
    stall = ex_valid_q && (haz_a || haz_b) && !flush;
`endif
  end

  assign bus.in_ready = rst_n && !stall;
  assign accept       = bus.in_valid && bus.in_ready;
  assign advance      = ex_valid_q && !flush && !stall;
  assign sum          = op_a + op_b;
  assign diff         = op_a - op_b;

  // ALU result and signed-overflow flag for the operation in EX.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ex_op_q.ctl)
      AluAnd: alu_res = op_a & op_b;
      AluOr:  alu_res = op_a | op_b;
      AluXor: alu_res = op_a ^ op_b;
      AluAdd: begin
        alu_res = sum;
        alu_ovf = (op_a[XLEN-1] == op_b[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);
      end
      AluSub: begin
        alu_res = diff;
        alu_ovf = (op_a[XLEN-1] != op_b[XLEN-1]) && (diff[XLEN-1] != op_a[XLEN-1]);
      end
      AluSll: alu_res = op_a << op_b[SW-1:0];
      AluSrl: alu_res = op_a >> op_b[SW-1:0];
      AluSra: alu_res = $signed(op_a) >>> op_b[SW-1:0];
      AluSlt: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  // Next state for EX, WB and the register file.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_op_d    = ex_op_q;
    if (accept) begin
      ex_valid_d = 1'b1;
      ex_op_d    = '{rs1: bus.in_rs1, rs2: bus.in_rs2, rd: bus.in_rd, ctl: bus.in_alu_ctl,
                     use_imm: bus.in_use_imm, imm: bus.in_imm, reg_write: bus.in_reg_write};
    end else if (!stall) begin
      ex_valid_d = 1'b0;
    end

    wb_valid_d     = advance;
    wb_data_d      = wb_data_q;
    wb_rd_d        = wb_rd_q;
    wb_reg_write_d = wb_reg_write_q;
    wb_zero_d      = wb_zero_q;
    wb_ovf_d       = wb_ovf_q;
    if (advance) begin
      wb_data_d      = alu_res;
      wb_rd_d        = ex_op_q.rd;
      wb_reg_write_d = ex_op_q.reg_write;
      wb_zero_d      = (alu_res == '0);
      wb_ovf_d       = alu_ovf;
    end

    rf_d = rf_q;
    if (wb_commit) rf_d[wb_rd_q] = wb_data_q;
    rf_d[0] = '0;
  end

  // Pipeline and register-file state; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q     <= 1'b0;
      ex_op_q        <= '0;
      wb_valid_q     <= 1'b0;
      wb_data_q      <= '0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
      wb_zero_q      <= 1'b0;
      wb_ovf_q       <= 1'b0;
      rf_q           <= '{default: '0};
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_op_q        <= ex_op_d;
      wb_valid_q     <= wb_valid_d;
      wb_data_q      <= wb_data_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_zero_q      <= wb_zero_d;
      wb_ovf_q       <= wb_ovf_d;
      rf_q           <= rf_d;
    end
  end

  assign bus.res_valid    = wb_valid_q;
  assign bus.res_data     = wb_data_q;
  assign bus.res_rd       = wb_rd_q;
  assign bus.res_zero     = wb_zero_q;
  assign bus.res_overflow = wb_ovf_q;
  assign dbg_data         = rf_q[dbg_addr];
endmodule

// File: tb/tb_alu_exec_pipeline.sv
// Directed bench for alu_exec_pipeline; expected timing follows ALU_EXEC_FWD_EN.
module tb_alu_exec_pipeline;
  localparam logic [3:0] CtlAnd = 4'b0000;
  localparam logic [3:0] CtlOr  = 4'b0001;
  localparam logic [3:0] CtlAdd = 4'b0010;
  localparam logic [3:0] CtlXor = 4'b0011;
  localparam logic [3:0] CtlSll = 4'b0100;
  localparam logic [3:0] CtlSrl = 4'b0101;
  localparam logic [3:0] CtlSub = 4'b0110;
  localparam logic [3:0] CtlSlt = 4'b0111;
  localparam logic [3:0] CtlSra = 4'b1000;
  localparam logic [3:0] CtlBad = 4'b1111;

  localparam logic [63:0] AllOnes = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MaxPos  = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MinNeg  = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [4:0]  dbg_addr;
  logic [63:0] dbg_data;
  int          checks = 0;
  int          errors = 0;

  alu_exec_pipeline_if #(.XLEN(64), .NREGS(32), .IMMW(12)) bus ();

  alu_exec_pipeline #(.XLEN(64), .NREGS(32), .IMMW(12)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .flush    (flush),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [3:0] ctl, input logic use_imm, input logic [11:0] imm);
    bus.in_valid     = 1'b1;
    bus.in_rd        = rd;
    bus.in_rs1       = rs1;
    bus.in_rs2       = rs2;
    bus.in_alu_ctl   = ctl;
    bus.in_use_imm   = use_imm;
    bus.in_imm       = imm;
    bus.in_reg_write = 1'b1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] addr, input logic [63:0] exp);
    dbg_addr = addr;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic chk_res(input string tag, input logic [63:0] data, input logic [4:0] rd);
    chk({tag, ".valid"}, bus.res_valid, 1'b1);
    chk({tag, ".data"}, bus.res_data, data);
    chk({tag, ".rd"}, bus.res_rd, rd);
  endtask

  // Issue one op into an empty pipeline and check its WB result and flags.
  task automatic exec(input string tag, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [3:0] ctl, input logic use_imm,
                      input logic [11:0] imm, input logic [63:0] exp_data, input logic exp_ovf);
    set_op(rd, rs1, rs2, ctl, use_imm, imm);
    chk({tag, ".ready"}, bus.in_ready, 1'b1);
    tick();
    idle();
    tick();
    chk_res(tag, exp_data, rd);
    chk({tag, ".zero"}, bus.res_zero, exp_data == 64'd0);
    chk({tag, ".ovf"}, bus.res_overflow, exp_ovf);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    dbg_addr = '0;
    bus.in_valid = 1'b0;
    bus.in_rd = '0;
    bus.in_rs1 = '0;
    bus.in_rs2 = '0;
    bus.in_alu_ctl = '0;
    bus.in_use_imm = 1'b0;
    bus.in_imm = '0;
    bus.in_reg_write = 1'b0;

    // Reset state.
    tick();
    chk("rst.ready", bus.in_ready, 1'b0);
    chk("rst.res_valid", bus.res_valid, 1'b0);
    chk("rst.res_data", bus.res_data, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst.ready_after", bus.in_ready, 1'b1);

    // Dependent back-to-back pair: ADDI x1 = 5, ADD x2 = x1 + x1.
    set_op(5'd1, 5'd0, 5'd0, CtlAdd, 1'b1, 12'd5);
    tick();
    set_op(5'd2, 5'd1, 5'd1, CtlAdd, 1'b0, 12'd0);
    chk("dep.ready0", bus.in_ready, 1'b1);
    tick();
    idle();
    chk_res("dep.r1", 64'd5, 5'd1);
`ifdef ALU_EXEC_FWD_EN
    chk("dep.ready1", bus.in_ready, 1'b1);
    tick();
    chk_res("dep.r2", 64'd10, 5'd2);
`else
    chk("dep.stall", bus.in_ready, 1'b0);
    tick();
    chk("dep.bubble", bus.res_valid, 1'b0);
    chk("dep.ready1", bus.in_ready, 1'b1);
    tick();
    chk_res("dep.r2", 64'd10, 5'd2);
`endif
    tick();
    chk_reg("dep.x1", 5'd1, 64'd5);
    chk_reg("dep.x2", 5'd2, 64'd10);

    // Overflow, zero and the other ALU codes.
    exec("addi_m1", 5'd3, 5'd0, 5'd0, CtlAdd, 1'b1, 12'hFFF, AllOnes, 1'b0);
    exec("srli1", 5'd3, 5'd3, 5'd0, CtlSrl, 1'b1, 12'd1, MaxPos, 1'b0);
    exec("add_ovf", 5'd8, 5'd3, 5'd0, CtlAdd, 1'b1, 12'd1, MinNeg, 1'b1);
    exec("addi5", 5'd9, 5'd0, 5'd0, CtlAdd, 1'b1, 12'd5, 64'd5, 1'b0);
    exec("sub_zero", 5'd10, 5'd9, 5'd9, CtlSub, 1'b0, 12'd0, 64'd0, 1'b0);
    exec("x4", 5'd4, 5'd0, 5'd0, CtlAdd, 1'b1, 12'hFFF, AllOnes, 1'b0);
    exec("x5", 5'd5, 5'd0, 5'd0, CtlAdd, 1'b1, 12'd1, 64'd1, 1'b0);
    exec("slt", 5'd12, 5'd4, 5'd5, CtlSlt, 1'b0, 12'd0, 64'd1, 1'b0);
    exec("sra4", 5'd13, 5'd8, 5'd0, CtlSra, 1'b1, 12'd4, 64'hF800_0000_0000_0000, 1'b0);
    exec("bad_code", 5'd14, 5'd9, 5'd9, CtlBad, 1'b0, 12'd0, 64'd0, 1'b0);
    exec("sub_ovf", 5'd15, 5'd8, 5'd5, CtlSub, 1'b0, 12'd0, MaxPos, 1'b1);
    exec("andi", 5'd18, 5'd3, 5'd0, CtlAnd, 1'b1, 12'h0F0, 64'hF0, 1'b0);
    exec("ori", 5'd19, 5'd9, 5'd0, CtlOr, 1'b1, 12'h0A0, 64'hA5, 1'b0);
    exec("xor", 5'd20, 5'd4, 5'd5, CtlXor, 1'b0, 12'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    exec("sll63", 5'd21, 5'd5, 5'd0, CtlSll, 1'b1, 12'd63, MinNeg, 1'b0);
    exec("srl63", 5'd22, 5'd4, 5'd0, CtlSrl, 1'b1, 12'd63, 64'd1, 1'b0);

    // Write to x0 followed immediately by a read of x0: no bypass, no stall.
    set_op(5'd0, 5'd0, 5'd0, CtlAdd, 1'b1, 12'd7);
    tick();
    set_op(5'd11, 5'd0, 5'd0, CtlAdd, 1'b0, 12'd0);
    tick();
    idle();
    chk_res("x0w", 64'd7, 5'd0);
    chk("x0w.ready", bus.in_ready, 1'b1);
    tick();
    chk_res("x0r", 64'd0, 5'd11);
    chk("x0r.zero", bus.res_zero, 1'b1);
    tick();
    chk_reg("x0.reg", 5'd0, 64'd0);
    chk_reg("x11.reg", 5'd11, 64'd0);

    // Flush the op in EX while a new op is accepted on the same edge.
    set_op(5'd6, 5'd0, 5'd0, CtlAdd, 1'b1, 12'd9);
    tick();
    set_op(5'd7, 5'd0, 5'd0, CtlAdd, 1'b1, 12'd3);
    flush = 1'b1;
    chk("flush.ready", bus.in_ready, 1'b1);
    tick();
    flush = 1'b0;
    idle();
    chk("flush.bubble", bus.res_valid, 1'b0);
    tick();
    chk_res("flush.x7", 64'd3, 5'd7);
    tick();
    chk_reg("flush.x6", 5'd6, 64'd0);
    chk_reg("flush.x7reg", 5'd7, 64'd3);

    // Reset with two ops in flight.
    set_op(5'd16, 5'd0, 5'd0, CtlAdd, 1'b1, 12'd1);
    tick();
    set_op(5'd17, 5'd0, 5'd0, CtlAdd, 1'b1, 12'd2);
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    chk("mrst.res_valid", bus.res_valid, 1'b0);
    chk("mrst.res_data", bus.res_data, 64'd0);
    chk("mrst.res_rd", bus.res_rd, 5'd0);
    chk("mrst.ready", bus.in_ready, 1'b0);
    chk_reg("mrst.x1", 5'd1, 64'd0);
    chk_reg("mrst.x3", 5'd3, 64'd0);
    tick();
    rst_n = 1'b1;
    set_op(5'd23, 5'd0, 5'd0, CtlAdd, 1'b1, 12'd4);
    #1;
    chk("post.ready", bus.in_ready, 1'b1);
    tick();
    idle();
    chk("post.lat1", bus.res_valid, 1'b0);
    tick();
    chk_res("post", 64'd4, 5'd23);
    tick();
    chk_reg("post.x23", 5'd23, 64'd4);
    chk_reg("post.x17", 5'd17, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_exec_pipeline.md
# alu_exec_pipeline

Parametrised three-stage integer execute pipeline (issue → execute → writeback) that replaces the single-cycle R/I-type datapath. It accepts pre-decoded operations through a valid/ready handshake, reads a parametrised register file, executes on a registered ALU stage, and writes back one cycle later. RAW hazards are resolved by a writeback bypass, or by an interlock when bypassing is compiled out. It sits between the instruction decode/control units and the load/store and branch logic.

## Interface
- XLEN, 64, datapath width in bits.
- NREGS, 32, register count; AW = $clog2(NREGS); register 0 reads as zero and ignores writes.
- IMMW, 12, immediate width; sign-extended to XLEN.
- clock  in  1  rising-edge clock.
- reset  in  1  reset is asynchronous and active-low.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted on an edge where in_valid && in_ready.
- in_rs1, in_rs2, in_rd  in  AW  source and destination indices.
- in_alu_ctl  in  4  ALU control code.
- in_use_imm  in  1  operand B = sext(in_imm) instead of rs2.
- in_imm  in  IMMW  immediate.
- in_reg_write  in  1  write the result to rd.
- flush  in  1  kill the operation currently in execute.
- res_valid  out  1  one-cycle pulse: the writeback stage holds a valid result.
- res_data  out  XLEN  result.
- res_rd  out  AW  destination of the result.
- res_zero, res_overflow  out  1  result == 0; signed overflow (ADD/SUB only, 0 otherwise).
- dbg_addr  in  AW; dbg_data  out  XLEN: combinational register-file read, post-commit value, no bypass.

## Operation
- Stages: EX register (captured on accept), WB register (captured from the ALU), register file (written from WB).
- ALU codes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed, result 0/1), 1000 SRA; any other code → result 0, overflow 0.
- Shift amount is operand B[$clog2(XLEN)-1:0]. ADD/SUB wrap modulo 2^XLEN.
- Operands are read in the EX stage. If the WB stage is valid, in_reg_write, rd ≠ 0 and rd matches rs1 or rs2, that operand hazards on WB.
- Writeback: on an edge with WB valid, reg_write set and rd ≠ 0, regfile[rd] ← res_data.
- flush: the EX-stage operation is not transferred to WB (bubble). An operation accepted on the same edge still enters EX; flush applies only to the older operation. WB is never killed.
- Reset (any time, including mid-operation): all stage valids 0, res_data/res_rd/flags 0, all registers 0, in_ready 0 while reset is asserted. In-flight operations are discarded.

## Timing
- Accept at edge N; result registered at edge N+1; res_valid high in cycle N+1..N+2; regfile written at edge N+2; dbg_data reflects it after N+2.
- Throughput: one operation per cycle with bypass enabled.
- in_ready = reset deasserted && !stall; no output backpressure.
- Back-to-back dependent operations (accepted at N and N+1) require the N result at N+1's execute.

## Configuration
- ALU_EXEC_FWD_EN defined: a WB hazard selects res_data as the operand (bypass). in_ready stays 1 after reset; zero stall cycles.
- Not defined: a WB hazard stalls. EX holds, a bubble is inserted into WB, and in_ready = 0 for exactly one cycle. The operand is read from the register file after commit. Dependent back-to-back pairs therefore issue every 2 cycles.

## Test plan
- ADDI x1 = x0 + 5, then ADD x2 = x1 + x1 back-to-back -> res 5 then 10. With FWD_EN: res_valid in consecutive cycles. Without: one in_ready=0 cycle and one bubble.
- ADD with x3 = 0x7FFF_FFFF_FFFF_FFFF and imm 1 -> res 0x8000_0000_0000_0000, res_overflow=1. SUB 5-5 -> res 0, res_zero=1.
- Write to x0 (ADDI x0 = x0 + 7) -> res_valid with res_data 7; dbg_data(x0) remains 0. A following op reading x0 gets 0 (no bypass).
- SLT with x4 = -1, x5 = 1 -> 1. SRA of 0x8000_0000_0000_0000 by 4 -> 0xF800_0000_0000_0000. Code 1111 -> 0.
- flush asserted while the op writing x6 = 9 is in EX, with a new ADDI x7 = x0 + 3 accepted on the same edge -> no result for x6, which stays 0; x7 = 3 two cycles later.
- reset asserted mid-stream with two ops in flight -> res_valid, res_data and all registers 0 immediately, and in_ready=0. After release, the first op completes with latency 2.
